// File: rtl/code_defs_pkg.sv
// Shared PCS receive definitions: link FSM states, sync header codes and
// helpers used by the link controller and its BER monitor.
package code_defs_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_LOCKED    = 2'd2
  } link_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [5:0] BER_COUNT_MAX = 6'd63;
  localparam logic [7:0] RELOCK_MAX    = 8'd255;

  // Only 01 and 10 are legal 64b/66b sync headers.
  function automatic logic header_invalid(input logic [1:0] header);
    return !((header == SYNC_DATA) || (header == SYNC_CTRL));
  endfunction

endpackage

// File: rtl/pcs_ber_monitor.sv
// BER monitor over windows of header-valid blocks: counts invalid sync
// headers, flags hi_ber and tracks the run of consecutive hi_ber windows.
module pcs_ber_monitor
  import code_defs_pkg::*;
#(
  parameter int BER_WINDOW       = 19531,
  parameter int BER_THRESH       = 16,
  parameter int HI_BER_RESET_WIN = 8,
  localparam int WW = $clog2(BER_WINDOW),
  localparam int RW = $clog2(HI_BER_RESET_WIN + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic [1:0]    i_header,
  input  logic          i_header_valid,
  output logic          hi_ber,
  output logic [5:0]    ber_count,
  output logic [RW-1:0] hi_ber_windows
);

  localparam logic [5:0]    THRESH  = 6'(BER_THRESH);
  localparam logic [WW-1:0] WIN_END = WW'(BER_WINDOW - 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(HI_BER_RESET_WIN);

  logic [WW-1:0] win_cnt;
  logic [5:0]    err_cnt;
  logic [5:0]    err_next;
  logic          win_last;
  logic          final_hi;

  // err_next already includes the current block, so the last block of a
  // window is counted in that window's final result.
  always_comb begin
    err_next = err_cnt;
    if (i_header_valid && header_invalid(i_header) && (err_cnt != BER_COUNT_MAX))
      err_next = err_cnt + 6'd1;
    win_last = i_header_valid && (win_cnt == WIN_END);
    final_hi = (err_next >= THRESH);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      win_cnt        <= '0;
      err_cnt        <= '0;
      hi_ber         <= 1'b0;
      ber_count      <= '0;
      hi_ber_windows <= '0;
    end else if (i_clear) begin
      // ber_count deliberately survives a clear so the last result stays visible
      win_cnt        <= '0;
      err_cnt        <= '0;
      hi_ber         <= 1'b0;
      hi_ber_windows <= '0;
    end else begin
      if (err_cnt >= THRESH)
        hi_ber <= 1'b1;
      if (i_header_valid) begin
        if (win_last) begin
          win_cnt   <= '0;
          err_cnt   <= '0;
          ber_count <= err_next;
          hi_ber    <= final_hi;
          if (!final_hi)
            hi_ber_windows <= '0;
          else if (hi_ber_windows != RUN_MAX)
            hi_ber_windows <= hi_ber_windows + RW'(1);
        end else begin
          win_cnt <= win_cnt + WW'(1);
          err_cnt <= err_next;
        end
      end
    end
  end

endmodule

// File: rtl/pcs_link_ctrl.sv
// RX link controller: sequences the PCS rx reset, waits for block lock with
// timeout/retry, and reports link status from the BER monitor.
module pcs_link_ctrl
  import code_defs_pkg::*;
#(
  parameter int RESET_CYCLES     = 16,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int BER_WINDOW       = 19531,
  parameter int BER_THRESH       = 16,
  parameter int HI_BER_RESET_WIN = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_header,
  input  logic        i_header_valid,
  input  logic        i_block_lock,
  output logic        o_pcs_rx_reset,
  output logic        o_link_up,
  output logic        o_hi_ber,
  output logic [5:0]  o_ber_count,
  output logic [7:0]  o_relock_count,
  output link_state_t o_state
);

  localparam int TMAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(HI_BER_RESET_WIN + 1);

  localparam logic [TW-1:0] RESET_END = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_END  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RUN_LIMIT = RW'(HI_BER_RESET_WIN);

  link_state_t   state;
  link_state_t   state_next;
  logic [TW-1:0] timer;
  logic          relock;
  logic          mon_clear;
  logic          hi_ber;
  logic [RW-1:0] hi_ber_windows;

  // BER history only means something while locked; lock loss wipes it.
  assign mon_clear = (state != ST_LOCKED) || !i_block_lock;

  pcs_ber_monitor #(
    .BER_WINDOW       (BER_WINDOW),
    .BER_THRESH       (BER_THRESH),
    .HI_BER_RESET_WIN (HI_BER_RESET_WIN)
  ) u_ber (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_clear        (mon_clear),
    .i_header       (i_header),
    .i_header_valid (i_header_valid),
    .hi_ber         (hi_ber),
    .ber_count      (o_ber_count),
    .hi_ber_windows (hi_ber_windows)
  );

  always_comb begin
    state_next = state;
    relock     = 1'b0;
    case (state)
      ST_RESET: begin
        if (timer == RESET_END)
          state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (i_block_lock) begin
          state_next = ST_LOCKED;
        end else if (timer == LOCK_END) begin
          state_next = ST_RESET;
          relock     = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!i_block_lock) begin
          state_next = ST_WAIT_LOCK;
        end else if (hi_ber_windows >= RUN_LIMIT) begin
          state_next = ST_RESET;
          relock     = 1'b1;
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_RESET;
      timer          <= '0;
      o_pcs_rx_reset <= 1'b1;
      o_link_up      <= 1'b0;
      o_relock_count <= '0;
    end else begin
      state          <= state_next;
      timer          <= ((state_next != state) || (state == ST_LOCKED)) ? '0 : timer + TW'(1);
      o_pcs_rx_reset <= (state_next == ST_RESET);
      o_link_up      <= (state == ST_LOCKED) && i_block_lock && !hi_ber;
      if (relock && (o_relock_count != RELOCK_MAX))
        o_relock_count <= o_relock_count + 8'd1;
    end
  end

  assign o_hi_ber = hi_ber;
  assign o_state  = state;

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Bench for pcs_link_ctrl: directed stimulus pushes cycle-stamped expected
// output snapshots; a negedge monitor pops and compares them.
module tb_pcs_link_ctrl;
  import code_defs_pkg::*;

  localparam int W = 49;  // {cycle[31:0], rx_reset, link_up, hi_ber, ber_count[5:0], relock[7:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  header;
  logic        header_valid;
  logic        block_lock;
  logic        pcs_rx_reset;
  logic        link_up;
  logic        hi_ber;
  logic [5:0]  ber_count;
  logic [7:0]  relock_count;
  link_state_t state;

  logic [W-1:0] exp_q[$];
  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcs_link_ctrl #(
    .RESET_CYCLES     (4),
    .LOCK_TIMEOUT     (20),
    .BER_WINDOW       (8),
    .BER_THRESH       (3),
    .HI_BER_RESET_WIN (2)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_header       (header),
    .i_header_valid (header_valid),
    .i_block_lock   (block_lock),
    .o_pcs_rx_reset (pcs_rx_reset),
    .o_link_up      (link_up),
    .o_hi_ber       (hi_ber),
    .o_ber_count    (ber_count),
    .o_relock_count (relock_count),
    .o_state        (state)
  );

  // scoreboard
  task automatic expect_at(input int c, input logic rr, input logic lu, input logic hb,
                           input logic [5:0] bc, input logic [7:0] rc);
    exp_q.push_back({32'(c), rr, lu, hb, bc, rc});
  endtask

  logic [W-1:0] mon_e;
  logic [16:0]  mon_got;
  always @(negedge clk) begin
    while ((exp_q.size() > 0) && (int'(exp_q[0][48:17]) < cyc)) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_check cycle %0d (now %0d)", int'(mon_e[48:17]), cyc);
    end
    if ((exp_q.size() > 0) && (int'(exp_q[0][48:17]) == cyc)) begin
      mon_e   = exp_q.pop_front();
      mon_got = {pcs_rx_reset, link_up, hi_ber, ber_count, relock_count};
      n_checks++;
      if (mon_got !== mon_e[16:0]) begin
        n_fail++;
        $display("FAIL outputs@%0d rx_reset/link_up/hi_ber/ber_count/relock got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                 cyc, mon_got[16], mon_got[15], mon_got[14], mon_got[13:8], mon_got[7:0],
                 mon_e[16], mon_e[15], mon_e[14], mon_e[13:8], mon_e[7:0]);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One block: valid for one cycle, then an idle cycle that must advance nothing.
  task automatic send(input logic [1:0] h);
    header_valid = 1'b1;
    header       = h;
    step();
    header_valid = 1'b0;
    header       = SYNC_DATA;
    step();
  endtask

  // hs holds block k in bits [2k+1:2k]; block k is sampled on edge start+1+2k.
  task automatic send_window(input logic [15:0] hs);
    for (int k = 0; k < 8; k++) send(hs[2*k +: 2]);
  endtask

  int s;
  int r;
  int ns[7] = '{1, 2, 3, 254, 255, 256, 258};

  initial begin
    reset        = 1'b1;
    header       = SYNC_DATA;
    header_valid = 1'b0;
    block_lock   = 1'b0;

    // Reset state, release, rx_reset for 4 cycles, lock 2 cycles later.
    expect_at(3, 1, 0, 0, 0, 0);
    steps(3);
    s = cyc;
    reset = 1'b0;
    expect_at(s + 3, 1, 0, 0, 0, 0);
    expect_at(s + 4, 0, 0, 0, 0, 0);
    expect_at(s + 6, 0, 0, 0, 0, 0);
    expect_at(s + 7, 0, 1, 0, 0, 0);
    steps(5);
    block_lock = 1'b1;
    steps(2);

    // Two invalid headers: below threshold.
    s = cyc;
    expect_at(s + 8,  0, 1, 0, 0, 0);
    expect_at(s + 15, 0, 1, 0, 2, 0);
    send_window({2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01});

    // 00,11,00 in blocks 0-2: hi_ber mid-window, link drops.
    s = cyc;
    expect_at(s + 5,  0, 1, 0, 2, 0);
    expect_at(s + 6,  0, 1, 1, 2, 0);
    expect_at(s + 7,  0, 0, 1, 2, 0);
    expect_at(s + 15, 0, 0, 1, 3, 0);
    send_window({2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00});

    // Clean window clears hi_ber at its end.
    s = cyc;
    expect_at(s + 14, 0, 0, 1, 3, 0);
    expect_at(s + 15, 0, 0, 0, 0, 0);
    expect_at(s + 16, 0, 1, 0, 0, 0);
    send_window({8{2'b01}});

    // Two consecutive hi_ber windows force a PCS re-reset.
    s = cyc;
    expect_at(s + 6,  0, 1, 1, 0, 0);
    expect_at(s + 7,  0, 0, 1, 0, 0);
    expect_at(s + 15, 0, 0, 1, 3, 0);
    send_window({2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00});
    s = cyc;
    expect_at(s + 15, 0, 0, 1, 3, 0);
    expect_at(s + 16, 1, 0, 1, 3, 1);
    expect_at(s + 17, 1, 0, 0, 3, 1);
    expect_at(s + 19, 1, 0, 0, 3, 1);
    expect_at(s + 20, 0, 0, 0, 3, 1);
    expect_at(s + 21, 0, 0, 0, 3, 1);
    expect_at(s + 22, 0, 1, 0, 3, 1);
    send_window({2'b11, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01});
    steps(6);

    // Lock dropped on the edge the second hi_ber window closes: no re-reset.
    s = cyc;
    expect_at(s + 6,  0, 1, 1, 3, 1);
    expect_at(s + 7,  0, 0, 1, 3, 1);
    expect_at(s + 15, 0, 0, 1, 3, 1);
    send_window({2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00});
    s = cyc;
    expect_at(s + 15, 0, 0, 0, 3, 1);
    expect_at(s + 20, 0, 0, 0, 3, 1);
    expect_at(s + 22, 0, 1, 0, 3, 1);
    expect_at(s + 23, 0, 1, 0, 3, 1);
    expect_at(s + 24, 0, 0, 0, 3, 1);
    expect_at(s + 26, 0, 1, 0, 3, 1);
    expect_at(s + 30, 0, 1, 0, 3, 1);
    expect_at(s + 31, 1, 0, 0, 0, 0);
    send(2'b00);
    send(2'b11);
    send(2'b00);
    for (int k = 0; k < 4; k++) send(SYNC_CTRL);
    block_lock   = 1'b0;
    header_valid = 1'b1;
    header       = SYNC_DATA;
    step();
    header_valid = 1'b0;
    steps(5);
    block_lock = 1'b1;
    steps(3);
    block_lock = 1'b0;
    step();
    block_lock = 1'b1;
    step();
    step();
    send(2'b11);
    send(2'b11);
    // i_reset while locked mid-window.
    reset = 1'b1;
    step();
    step();

    // Lock held low: re-pulse every 24 cycles, relock count saturates at 255.
    r = cyc;
    reset      = 1'b0;
    block_lock = 1'b0;
    expect_at(r + 3, 1, 0, 0, 0, 0);
    expect_at(r + 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      expect_at(r + 24 * ns[i] - 1, 0, 0, 0, 0, (ns[i] - 1 > 255) ? 8'd255 : 8'(ns[i] - 1));
      expect_at(r + 24 * ns[i],     1, 0, 0, 0, (ns[i] > 255) ? 8'd255 : 8'(ns[i]));
    end
    steps(24 * 258 + 2);

    steps(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_checks got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
